sfx_sequencer: RTL

//  Sound-effect controller for the Breakout audio path. Arbitrates game-event requests
//  (paddle hit, brick hit, wall hit, life lost) and plays each effect's note sequence.

---
 rtl/sfx_sequencer_if.sv | 21 ++
 rtl/sfx_sequencer.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/sfx_sequencer_if.sv
// Event-request / tone-output bundle between the game logic and the sound-effect sequencer.
// The game side (master) raises request pulses; the sequencer (slave) reports playback status.
interface sfx_sequencer_if;
  logic [3:0] req;
  logic [4:0] tono_addr;
  logic       tone_on;
  logic       busy;
  logic [1:0] effect_id;
  logic [1:0] note_id;
  logic       done;

  modport master (
    output req,
    input  tono_addr, tone_on, busy, effect_id, note_id, done
  );

  modport slave (
    input  req,
    output tono_addr, tone_on, busy, effect_id, note_id, done
  );
endinterface

// File: rtl/sfx_sequencer.sv
// Breakout sound-effect sequencer: arbitrates event requests (highest index wins, higher
// requests preempt the running effect) and walks each effect's notes, stepping the sine
// ROM address at a per-note rate derived from clock-enable counting in the clk50mhz domain.
module sfx_sequencer #(
  parameter int NOTE_TICKS = 4_000_000,
  parameter int GAP_TICKS  = 500_000,
  parameter int LIM_DO     = 'hBAA,
  parameter int LIM_RE     = 'hA64,
  parameter int LIM_MI     = 'h941,
  parameter int LIM_SOL    = 'h7C9,
  parameter int CNT_W      = 24
) (
  input  logic            clk50mhz,
  input  logic            reset_button,
  sfx_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] NOTE_LAST = CNT_W'(NOTE_TICKS - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_TICKS - 1);

  state_t           state, state_n;
  logic [3:0]       pending;
  logic [CNT_W-1:0] tick, step;
  logic [4:0]       tono_addr;
  logic [1:0]       effect_id, note_id;
  logic             done;

  logic [3:0] act;
  logic       any_req;
  logic [1:0] hi;
  logic       preempt, note_end, gap_end, last_note, start, finish, next_note;
  logic [CNT_W-1:0] step_last;

  // Last step index of the current note: two half-periods of that note's pitch.
  function automatic logic [CNT_W-1:0] note_step_last(input logic [1:0] eff,
                                                      input logic [1:0] note);
    int lim;
    case ({eff, note})
      4'b00_00: lim = LIM_DO;
      4'b01_00: lim = LIM_RE;
      4'b10_00: lim = LIM_MI;
      4'b10_01: lim = LIM_SOL;
      4'b11_00: lim = LIM_SOL;
      4'b11_01: lim = LIM_MI;
      4'b11_10: lim = LIM_RE;
      4'b11_11: lim = LIM_DO;
      default:  lim = LIM_DO;
    endcase
    return CNT_W'(2 * lim - 1);
  endfunction

  // Arbitration and event decode shared by the next-state and datapath logic.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    hi = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (act[i]) hi = 2'(i);
    end
    case (effect_id)
      2'd2:    last_note = (note_id == 2'd1);
      2'd3:    last_note = (note_id == 2'd3);
      default: last_note = (note_id == 2'd0);
    endcase
  end

  assign act       = pending | bus.req;
  assign any_req   = |act;
  assign note_end  = (tick == NOTE_LAST);
  assign gap_end   = (tick == GAP_LAST);
  assign preempt   = (state != IDLE) && any_req && (hi > effect_id);
  assign finish    = (state == GAP) && !preempt && gap_end && last_note;
  assign next_note = (state == GAP) && !preempt && gap_end && !last_note;
  assign start     = ((state == IDLE) && any_req) || preempt || (finish && any_req);
  assign step_last = note_step_last(effect_id, note_id);

  // State register.
  always_ff @(posedge clk50mhz) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset_button) state <= IDLE;
    else              state <= state_n;
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (any_req) state_n = PLAY;
      PLAY: begin
        if (preempt)       state_n = PLAY;
        else if (note_end) state_n = GAP;
      end
      GAP: begin
        if (preempt)                 state_n = PLAY;
        else if (next_note)          state_n = PLAY;
        else if (finish && any_req)  state_n = PLAY;
        else if (finish)             state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Output decode from state.
  always_comb begin
    bus.tone_on = (state == PLAY);
    bus.busy    = (state != IDLE);
  end

  // Datapath: pending queue, note timing, ROM address stepping and done pulse.
  always_ff @(posedge clk50mhz) begin
    // NOTE: every register here has a defined reset value; a reset abandons playback entirely.
    if (reset_button) begin
      pending   <= '0;
      tick      <= '0;
      step      <= '0;
      tono_addr <= '0;
      effect_id <= '0;
      note_id   <= '0;
      done      <= 1'b0;
    end else begin
      pending <= act & ~(start ? (4'b0001 << hi) : 4'b0000);
      done    <= finish;
      if (start) begin
        effect_id <= hi;
        note_id   <= '0;
        tick      <= '0;
        step      <= '0;
        tono_addr <= '0;
      end else begin
        case (state)
          PLAY: begin
            if (note_end) begin
              tick      <= '0;
              step      <= '0;
              tono_addr <= '0;
            end else begin
              tick <= tick + 1'b1;
              if (step == step_last) begin
                step      <= '0;
                tono_addr <= tono_addr + 5'd1;
              end else begin
                step <= step + 1'b1;
              end
            end
          end
          GAP: begin
            if (gap_end) begin
              tick <= '0;
              step <= '0;
              if (next_note) note_id <= note_id + 2'd1;
            end else begin
              tick <= tick + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.tono_addr = tono_addr;
  assign bus.effect_id = effect_id;
  assign bus.note_id   = note_id;
  assign bus.done      = done;

endmodule
